// File: rtl/apb_regfile_wait.sv
`default_nettype none
// ============================================================================
//  Module      : apb_regfile_wait
//  Description : Parametrised APB3 slave register file with configurable
//                wait states, PSLVERR on out-of-range or read-only writes,
//                and read-only status words taken from the core.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W      : byte address width; word index = I_PADDR[ADDR_W-1:2]
//    NUM_REGS    : number of 32-bit registers (1 .. 2**(ADDR_W-2))
//    WAIT_STATES : PREADY-low cycles per access phase (0 .. 15)
//    RO_MASK     : bit n set -> register n is read-only, reads I_STATUS word n
//  Optional build macro
//    APB_PSTRB_EN : when defined, writes honour I_PSTRB byte lanes;
//                   when undefined, every write updates all four bytes.
//  Ports
//    I_PCLK     in  1            clock, rising edge
//    I_PRESET   in  1            synchronous active-high reset
//    I_PSEL     in  1            APB select
//    I_PENABLE  in  1            APB enable
//    I_PWRITE   in  1            1 = write, 0 = read
//    I_PADDR    in  ADDR_W       byte address (bits [1:0] ignored)
//    I_PWDATA   in  32           write data
//    I_PSTRB    in  4            byte strobes (APB_PSTRB_EN only)
//    I_STATUS   in  NUM_REGS*32  status words from the core
//    O_PRDATA   out 32           read data, non-zero only in the ready cycle
//    O_PREADY   out 1            transfer complete
//    O_PSLVERR  out 1            error flag, only while O_PREADY is high
//    O_REGS     out NUM_REGS*32  flat RW register contents (RO words read 0)
//    O_WR_STB   out NUM_REGS     one-cycle pulse per committed write
// ============================================================================
module apb_regfile_wait #(
    parameter int                  ADDR_W      = 8,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = {NUM_REGS{1'b0}}
) (
    input  logic                     I_PCLK,
    input  logic                     I_PRESET,
    input  logic                     I_PSEL,
    input  logic                     I_PENABLE,
    input  logic                     I_PWRITE,
    input  logic [ADDR_W-1:0]        I_PADDR,
    input  logic [31:0]              I_PWDATA,
    input  logic [3:0]               I_PSTRB,
    input  logic [NUM_REGS*32-1:0]   I_STATUS,
    output logic [31:0]              O_PRDATA,
    output logic                     O_PREADY,
    output logic                     O_PSLVERR,
    output logic [NUM_REGS*32-1:0]   O_REGS,
    output logic [NUM_REGS-1:0]      O_WR_STB
);

    localparam int                IDX_W      = ADDR_W - 2;
    localparam logic [3:0]        C_WAIT     = WAIT_STATES[3:0];
    // One extra bit so NUM_REGS == 2**IDX_W is still representable.
    localparam logic [IDX_W:0]    C_NUM_REGS = NUM_REGS[IDX_W:0];

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [NUM_REGS-1:0]   r_wr_stb;

    logic [IDX_W:0]        w_idx;
    logic [NUM_REGS-1:0]   w_sel;
    logic                  w_oob;
    logic                  w_ro_hit;
    logic                  w_ready;
    logic                  w_err;
    logic                  w_commit;
    logic [31:0]           w_bmask;
    logic [31:0]           w_rd_mux;
    logic [31:0]           w_rd_word [NUM_REGS];
    logic                  w_unused_bits;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_idx    = {1'b0, I_PADDR[ADDR_W-1:2]};
    assign w_oob    = (w_idx >= C_NUM_REGS);
    assign w_ro_hit = |(w_sel & RO_MASK);

    generate
        for (genvar n = 0; n < NUM_REGS; n++) begin : g_sel
            localparam logic [IDX_W:0] C_IDX = (IDX_W + 1)'(n);
            assign w_sel[n] = (w_idx == C_IDX);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Ready / error / commit qualification.  Reset masks the ready cycle
    // so an access interrupted by reset neither completes nor writes.
    // ------------------------------------------------------------------
    assign w_ready  = (r_state == S_ACCESS) && I_PSEL && I_PENABLE &&
                      (r_cnt == 4'd0) && !I_PRESET;
    assign w_err    = w_ready && (w_oob || (I_PWRITE && w_ro_hit));
    assign w_commit = w_ready && I_PWRITE && !w_oob && !w_ro_hit;

`ifdef APB_PSTRB_EN
    assign w_bmask = {{8{I_PSTRB[3]}}, {8{I_PSTRB[2]}},
                      {8{I_PSTRB[1]}}, {8{I_PSTRB[0]}}};
`else
    assign w_bmask = 32'hFFFF_FFFF;
`endif

    // Address LSBs, strobes in the default build and status words of RW
    // registers carry no meaning here.
    assign w_unused_bits = ^{I_PADDR[1:0], I_PSTRB, I_STATUS};

    // ------------------------------------------------------------------
    // FSM: state and wait counter register
    // ------------------------------------------------------------------
    always_ff @(posedge I_PCLK) begin
        if (I_PRESET) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM: next state and counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                // PSEL with PENABLE but no preceding setup is ignored.
                if (I_PSEL && !I_PENABLE) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = C_WAIT;
                end
            end
            S_ACCESS: begin
                if (!I_PSEL) begin
                    w_state_nxt = S_IDLE;        // abort, nothing committed
                    w_cnt_nxt   = 4'd0;
                end else if (!I_PENABLE) begin
                    w_cnt_nxt   = C_WAIT;        // fresh setup phase
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = S_IDLE;        // ready cycle completes
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    generate
        for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
            if (RO_MASK[n]) begin : g_ro
                assign w_rd_word[n]        = I_STATUS[32*n +: 32];
                assign O_REGS[32*n +: 32]  = 32'd0;
            end else begin : g_rw
                logic [31:0] r_reg;
                always_ff @(posedge I_PCLK) begin
                    if (I_PRESET) begin
                        r_reg <= 32'd0;
                    end else if (w_commit && w_sel[n]) begin
                        r_reg <= (r_reg & ~w_bmask) | (I_PWDATA & w_bmask);
                    end
                end
                assign w_rd_word[n]        = r_reg;
                assign O_REGS[32*n +: 32]  = r_reg;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write strobes: pulse in the cycle after the commit edge
    // ------------------------------------------------------------------
    always_ff @(posedge I_PCLK) begin
        if (I_PRESET) begin
            r_wr_stb <= '0;
        end else if (w_commit) begin
            r_wr_stb <= w_sel;
        end else begin
            r_wr_stb <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = 32'd0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_sel[k]) begin
                w_rd_mux = w_rd_word[k];
            end
        end
    end

    assign O_PRDATA  = (w_ready && !I_PWRITE && !w_oob) ? w_rd_mux : 32'd0;
    assign O_PREADY  = w_ready;
    assign O_PSLVERR = w_err;
    assign O_WR_STB  = r_wr_stb;

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_wait.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_regfile_wait
//  Description : Directed self-checking bench for apb_regfile_wait. Two
//                instances: u_dut0 (no wait states, register 1 read-only)
//                and u_dut3 (three wait states, all RW).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_regfile_wait;

    logic          clk = 1'b0;
    logic          rst;
    logic          psel0, psel3, penable, pwrite;
    logic [7:0]    paddr;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [511:0]  status;

    logic [31:0]   prdata0, prdata3;
    logic          pready0, pready3, pslverr0, pslverr3;
    logic [511:0]  regs0, regs3;
    logic [15:0]   wr_stb0, wr_stb3;

    int            total = 0;
    int            bad   = 0;
    logic [31:0]   rd;
    logic          err;
    int            ncyc;
    logic          seen_ready;

    always #5 clk = ~clk;

    apb_regfile_wait #(
        .ADDR_W(8), .NUM_REGS(16), .WAIT_STATES(0), .RO_MASK(16'h0002)
    ) u_dut0 (
        .I_PCLK(clk), .I_PRESET(rst), .I_PSEL(psel0), .I_PENABLE(penable),
        .I_PWRITE(pwrite), .I_PADDR(paddr), .I_PWDATA(pwdata),
        .I_PSTRB(pstrb), .I_STATUS(status), .O_PRDATA(prdata0),
        .O_PREADY(pready0), .O_PSLVERR(pslverr0), .O_REGS(regs0),
        .O_WR_STB(wr_stb0)
    );

    apb_regfile_wait #(
        .ADDR_W(8), .NUM_REGS(16), .WAIT_STATES(3), .RO_MASK(16'h0000)
    ) u_dut3 (
        .I_PCLK(clk), .I_PRESET(rst), .I_PSEL(psel3), .I_PENABLE(penable),
        .I_PWRITE(pwrite), .I_PADDR(paddr), .I_PWDATA(pwdata),
        .I_PSTRB(pstrb), .I_STATUS(status), .O_PRDATA(prdata3),
        .O_PREADY(pready3), .O_PSLVERR(pslverr3), .O_REGS(regs3),
        .O_WR_STB(wr_stb3)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer. Returns at the ready cycle (+1) with PSEL still
    // high so a following call can start its setup in the very next cycle.
    task automatic xfer(input bit d3, input bit wr, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        output logic [31:0] rdo, output logic erro,
                        output int cyc);
        logic rdy;
        @(negedge clk);
        psel0 = !d3; psel3 = d3; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
        cyc = 1;
        @(negedge clk);
        penable = 1'b1;
        cyc++;
        #1;
        rdy = d3 ? pready3 : pready0;
        while (!rdy && cyc < 40) begin
            @(negedge clk);
            cyc++;
            #1;
            rdy = d3 ? pready3 : pready0;
        end
        check("xfer_timeout", {31'd0, rdy}, 32'd1);
        rdo  = d3 ? prdata3 : prdata0;
        erro = d3 ? pslverr3 : pslverr0;
    endtask

    task automatic idle();
        @(negedge clk);
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 8'h00; pwdata = 32'd0; pstrb = 4'hF;
        status = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_regs0_lo", regs0[31:0], 32'd0);
        check("rst_regs0_or", {31'd0, |regs0}, 32'd0);
        check("rst_regs3_or", {31'd0, |regs3}, 32'd0);
        check("rst_pready0", {31'd0, pready0}, 32'd0);
        check("rst_pslverr0", {31'd0, pslverr0}, 32'd0);
        check("rst_prdata0", prdata0, 32'd0);
        check("rst_wr_stb0", {16'd0, wr_stb0}, 32'd0);

        // Read every register after reset
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, 1'b0, 8'(i * 4), 32'd0, 4'hF, rd, err, ncyc);
            check("rst_read_data", rd, 32'd0);
            check("rst_read_err", {31'd0, err}, 32'd0);
        end
        idle();

        // Zero wait states: write then read 0x08
        xfer(1'b0, 1'b1, 8'h08, 32'hDEADBEEF, 4'hF, rd, err, ncyc);
        check("ws0_wr_cycles", ncyc, 32'd2);
        check("ws0_wr_err", {31'd0, err}, 32'd0);
        idle();
        check("ws0_stb_pulse", {16'd0, wr_stb0}, 32'h0000_0004);
        check("ws0_regs_w2", regs0[95:64], 32'hDEADBEEF);
        idle();
        check("ws0_stb_clear", {16'd0, wr_stb0}, 32'd0);
        xfer(1'b0, 1'b0, 8'h08, 32'd0, 4'hF, rd, err, ncyc);
        check("ws0_rd_cycles", ncyc, 32'd2);
        check("ws0_rd_data", rd, 32'hDEADBEEF);
        idle();
        check("ws0_prdata_idle", prdata0, 32'd0);

        // Three wait states: write then read 0x04
        xfer(1'b1, 1'b1, 8'h04, 32'hCAFEF00D, 4'hF, rd, err, ncyc);
        check("ws3_wr_cycles", ncyc, 32'd5);
        idle();
        check("ws3_stb_pulse", {16'd0, wr_stb3}, 32'h0000_0002);
        xfer(1'b1, 1'b0, 8'h04, 32'd0, 4'hF, rd, err, ncyc);
        check("ws3_rd_cycles", ncyc, 32'd5);
        check("ws3_rd_data", rd, 32'hCAFEF00D);
        idle();

        // Out-of-range index
        xfer(1'b0, 1'b1, 8'h40, 32'h12345678, 4'hF, rd, err, ncyc);
        check("oob_wr_err", {31'd0, err}, 32'd1);
        idle();
        check("oob_wr_stb", {16'd0, wr_stb0}, 32'd0);
        xfer(1'b0, 1'b0, 8'h40, 32'd0, 4'hF, rd, err, ncyc);
        check("oob_rd_data", rd, 32'd0);
        check("oob_rd_err", {31'd0, err}, 32'd1);
        idle();
        check("oob_err_idle", {31'd0, pslverr0}, 32'd0);

        // Read-only register 1 on u_dut0
        status[63:32] = 32'hA5A5A5A5;
        xfer(1'b0, 1'b1, 8'h04, 32'h0BADF00D, 4'hF, rd, err, ncyc);
        check("ro_wr_err", {31'd0, err}, 32'd1);
        idle();
        check("ro_wr_stb", {16'd0, wr_stb0}, 32'd0);
        check("ro_regs_w1", regs0[63:32], 32'd0);
        xfer(1'b0, 1'b0, 8'h04, 32'd0, 4'hF, rd, err, ncyc);
        check("ro_rd_data", rd, 32'hA5A5A5A5);
        check("ro_rd_err", {31'd0, err}, 32'd0);
        idle();

        // Back-to-back write/read on 0x10
        xfer(1'b0, 1'b1, 8'h10, 32'h0000_0001, 4'hF, rd, err, ncyc);
        xfer(1'b0, 1'b0, 8'h10, 32'd0, 4'hF, rd, err, ncyc);
        check("b2b_rd_cycles", ncyc, 32'd2);
        check("b2b_rd_data", rd, 32'h0000_0001);
        idle();

        // Drop PSEL mid-wait on u_dut3 (write of 0x55 to 0x0C)
        seen_ready = 1'b0;
        @(negedge clk);
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h0C; pwdata = 32'h55; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        #1 seen_ready = seen_ready | pready3;
        @(negedge clk);
        psel3 = 1'b0; penable = 1'b0;
        #1 seen_ready = seen_ready | pready3;
        repeat (3) begin
            @(negedge clk);
            #1 seen_ready = seen_ready | pready3;
        end
        check("abort_no_ready", {31'd0, seen_ready}, 32'd0);
        check("abort_regs_w3", regs3[127:96], 32'd0);
        check("abort_no_stb", {16'd0, wr_stb3}, 32'd0);
        xfer(1'b1, 1'b0, 8'h0C, 32'd0, 4'hF, rd, err, ncyc);
        check("abort_rd_cycles", ncyc, 32'd5);
        check("abort_rd_data", rd, 32'd0);
        idle();

        // Reset asserted during the access phase of a write on u_dut0
        @(negedge clk);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h0C; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; psel0 = 1'b0; penable = 1'b0;
        #1;
        check("rstacc_regs_w3", regs0[127:96], 32'd0);
        check("rstacc_regs_w2", regs0[95:64], 32'd0);
        check("rstacc_no_stb", {16'd0, wr_stb0}, 32'd0);
        xfer(1'b0, 1'b0, 8'h0C, 32'd0, 4'hF, rd, err, ncyc);
        check("rstacc_rd_data", rd, 32'd0);
        idle();

        // Byte strobes on register 5 (0x14)
        xfer(1'b0, 1'b1, 8'h14, 32'h11223344, 4'hF, rd, err, ncyc);
        xfer(1'b0, 1'b1, 8'h14, 32'hAABBCCDD, 4'b0101, rd, err, ncyc);
        idle();
        check("strb_stb_pulse", {16'd0, wr_stb0}, 32'h0000_0020);
        xfer(1'b0, 1'b0, 8'h14, 32'd0, 4'hF, rd, err, ncyc);
`ifdef APB_PSTRB_EN
        check("strb_rd_data", rd, 32'h11BB33DD);
`else
        check("strb_rd_data", rd, 32'hAABBCCDD);
`endif
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
